// File: rtl/fpu_issue_arbiter.sv
// fpu_issue_arbiter
// Round-robin issue arbiter that shares one pipelined FPU among NUM_REQ
// requesters. Each cycle, at most one valid requester wins. Its operands are
// registered into the FPU inputs. The winner's ID travels down a tag pipeline
// that is LATENCY+1 stages deep, so the ID reaches the last stage in the same
// cycle as the FPU result. The result and flags are then registered and
// strobed back to that requester.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   en                  issue enable (no grants while low)
//   req_valid/ready     per-requester handshake; ready is the one-hot grant
//   req_opa/opb         packed operands, requester i at [32i+31:32i]
//   req_fpu_op/rmode    packed opcode (3b) / rounding mode (2b)
//   opa/opb/fpu_op/rmode  registered FPU inputs
//   out, fpu_flags      FPU result and flags
//   rsp_valid           one-hot, one-cycle result strobe
//   rsp_out/rsp_flags   registered result and flags
//   perf_cnt            per-requester saturating grant counters (16b each)
//
// Build option: define FPU_ARB_PERF_EN to build the grant counters. Without
// it, perf_cnt is tied to zero.

module fpu_issue_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 4,
  parameter int IDW     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_opa,
  input  logic [NUM_REQ*32-1:0] req_opb,
  input  logic [NUM_REQ*3-1:0]  req_fpu_op,
  input  logic [NUM_REQ*2-1:0]  req_rmode,
  output logic [31:0]           opa,
  output logic [31:0]           opb,
  output logic [2:0]            fpu_op,
  output logic [1:0]            rmode,
  input  logic [31:0]           out,
  input  logic [7:0]            fpu_flags,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [31:0]           rsp_out,
  output logic [7:0]            rsp_flags,
  output logic [NUM_REQ*16-1:0] perf_cnt
);

  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     ptr_nxt;
  logic [IDW-1:0]     grant_id;
  logic               grant_found;
  logic [NUM_REQ-1:0] grant_vec;
  logic [31:0]        sel_opa;
  logic [31:0]        sel_opb;
  logic [2:0]         sel_op;
  logic [1:0]         sel_rmode;
  int                 arb_idx;

  logic [LATENCY:0]   tag_v;
  logic [IDW-1:0]     tag_id [0:LATENCY];

  // The search starts at ptr and wraps. The first valid requester found
  // wins, and its operand slices are selected in the same pass.
  always_comb begin
    grant_vec   = '0;
    grant_found = 1'b0;
    grant_id    = '0;
    sel_opa     = '0;
    sel_opb     = '0;
    sel_op      = '0;
    sel_rmode   = '0;
    arb_idx     = 0;
    if (en && !rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        arb_idx = int'({1'b0, ptr}) + k;
        if (arb_idx >= NUM_REQ) arb_idx = arb_idx - NUM_REQ;
        if (!grant_found && req_valid[arb_idx]) begin
          grant_found        = 1'b1;
          grant_id           = arb_idx[IDW-1:0];
          grant_vec[arb_idx] = 1'b1;
          sel_opa            = req_opa[arb_idx*32 +: 32];
          sel_opb            = req_opb[arb_idx*32 +: 32];
          sel_op             = req_fpu_op[arb_idx*3 +: 3];
          sel_rmode          = req_rmode[arb_idx*2 +: 2];
        end
      end
    end
  end

  assign req_ready = grant_vec;
  assign ptr_nxt   = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= '0;
      opa    <= '0;
      opb    <= '0;
      fpu_op <= '0;
      rmode  <= '0;
    end else if (grant_found) begin
      ptr    <= ptr_nxt;
      opa    <= sel_opa;
      opb    <= sel_opb;
      fpu_op <= sel_op;
      rmode  <= sel_rmode;
    end
  end

  // Only the valid bits need a reset. An ID is never used unless its
  // valid bit is set.
  always_ff @(posedge clk) begin
    if (rst) tag_v <= '0;
    else     tag_v <= {tag_v[LATENCY-1:0], grant_found};
  end

  always_ff @(posedge clk) begin
    tag_id[0] <= grant_id;
    for (int s = 1; s <= LATENCY; s++) tag_id[s] <= tag_id[s-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_out   <= '0;
      rsp_flags <= '0;
    end else begin
      rsp_valid <= '0;
      if (tag_v[LATENCY]) begin
        rsp_valid[tag_id[LATENCY]] <= 1'b1;
        rsp_out                    <= out;
        rsp_flags                  <= fpu_flags;
      end
    end
  end

`ifdef FPU_ARB_PERF_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_perf
    logic [15:0] cnt;
    always_ff @(posedge clk) begin
      if (rst)                                   cnt <= '0;
      else if (grant_vec[i] && cnt != 16'hFFFF)  cnt <= cnt + 16'd1;
    end
    assign perf_cnt[16*i +: 16] = cnt;
  end
`else
  assign perf_cnt = '0;
`endif

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// Bench for fpu_issue_arbiter. A stand-in FPU with 4-cycle latency feeds the
// DUT. The driver checks each cycle's grant against a directed expectation
// and queues the expected response. The monitor pops the queue and compares
// on every rsp_valid.
`timescale 1ns/1ps

module tb_fpu_issue_arbiter;

  localparam int N   = 4;
  localparam int LAT = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_opa, req_opb;
  logic [N*3-1:0]  req_fpu_op;
  logic [N*2-1:0]  req_rmode;
  logic [31:0]     opa, opb, out, rsp_out;
  logic [2:0]      fpu_op;
  logic [1:0]      rmode;
  logic [7:0]      fpu_flags, rsp_flags;
  logic [N-1:0]    rsp_valid;
  logic [N*16-1:0] perf_cnt;

  logic [31:0] b_opa [N];
  logic [31:0] b_opb [N];
  logic [2:0]  b_op  [N];
  logic [1:0]  b_rm  [N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_opa[32*g +: 32]  = b_opa[g];
    assign req_opb[32*g +: 32]  = b_opb[g];
    assign req_fpu_op[3*g +: 3] = b_op[g];
    assign req_rmode[2*g +: 2]  = b_rm[g];
  end

  fpu_issue_arbiter #(.NUM_REQ(N), .LATENCY(LAT), .IDW(2)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opa(req_opa), .req_opb(req_opb),
    .req_fpu_op(req_fpu_op), .req_rmode(req_rmode),
    .opa(opa), .opb(opb), .fpu_op(fpu_op), .rmode(rmode),
    .out(out), .fpu_flags(fpu_flags),
    .rsp_valid(rsp_valid), .rsp_out(rsp_out), .rsp_flags(rsp_flags),
    .perf_cnt(perf_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int seq    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in FPU. It decodes two known IEEE cases (1.0+2.0 and x/0). For
  // any other input it returns a cheap value that is unique to the operands.
  function automatic logic [39:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op, input logic [1:0] rm);
    if (op == 3'd0 && a == 32'h3F80_0000 && b == 32'h4000_0000) return {8'h00, 32'h4040_0000};
    if (op == 3'd3 && b == 32'h0) return {8'h81, 32'h7F80_0000};
    return {a[7:0] ^ b[7:0], (a + b) ^ {27'd0, op, rm}};
  endfunction

  logic [39:0] fpu_pipe [LAT];
  always @(posedge clk) begin
    fpu_pipe[0] <= fpu_model(opa, opb, fpu_op, rmode);
    for (int k = 1; k < LAT; k++) fpu_pipe[k] <= fpu_pipe[k-1];
  end
  assign {fpu_flags, out} = fpu_pipe[LAT-1];

  typedef struct {
    int          id;
    logic [31:0] res;
    logic [7:0]  flags;
    int          due;
  } exp_t;
  exp_t sb[$];

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response monitor. It pops one entry for every strobe, and it flags any
  // entry that passes its due cycle without a strobe.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid != '0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: cyc=%0d rsp_valid=%b expected none", cyc, rsp_valid);
      end else begin
        e = sb.pop_front();
        if (rsp_valid !== onehot(e.id) || rsp_out !== e.res || rsp_flags !== e.flags || cyc != e.due) begin
          errors++;
          $display("FAIL rsp: cyc=%0d valid=%b out=%h flags=%h expected cyc=%0d valid=%b out=%h flags=%h",
                   cyc, rsp_valid, rsp_out, rsp_flags, e.due, onehot(e.id), e.res, e.flags);
        end
      end
    end else if (sb.size() > 0 && cyc >= sb[0].due) begin
      checks++;
      errors++;
      e = sb.pop_front();
      $display("FAIL rsp_missing: cyc=%0d no strobe, expected id %0d", cyc, e.id);
    end
  end

  task automatic gen_ops();
    seq++;
    for (int i = 0; i < N; i++) begin
      b_opa[i] = 32'h1000_0000 * (i + 1) + 32'(seq);
      b_opb[i] = 32'h0001_0000 * 32'(seq) + 32'(i) + 32'd1;
      b_op[i]  = 3'(i + seq);
      b_rm[i]  = 2'(seq);
    end
  endtask

  // One cycle: present the valid mask, then check the grant against exp_g
  // (-1 means no grant). A grant queues its expected response.
  task automatic drive(input logic [N-1:0] vmask, input int exp_g, input bit hand = 1'b0,
                       input logic [31:0] h_out = '0, input logic [7:0] h_fl = '0);
    exp_t e;
    logic [39:0] m;
    if (!hand) gen_ops();
    req_valid = vmask;
    @(negedge clk);
    checks++;
    if (req_ready !== onehot(exp_g)) begin
      errors++;
      $display("FAIL grant: cyc=%0d req_ready=%b expected %b", cyc, req_ready, onehot(exp_g));
    end
    if (exp_g >= 0) begin
      m       = fpu_model(b_opa[exp_g], b_opb[exp_g], b_op[exp_g], b_rm[exp_g]);
      e.id    = exp_g;
      e.res   = hand ? h_out : m[31:0];
      e.flags = hand ? h_fl  : m[39:32];
      e.due   = cyc + LAT + 2;
      sb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input logic [N-1:0] vmask);
    rst = 1'b1;
    req_valid = vmask;
    sb.delete();
    @(negedge clk);
    chk("ready_in_reset", 128'(req_ready), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      drive('0, -1);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding", sb.size());
      sb.delete();
    end
    repeat (3) drive('0, -1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cyc %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b1; req_valid = '1;
    gen_ops();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_ready", 128'(req_ready), 128'(0));
    chk("reset_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("reset_rsp_out_flags", 128'({rsp_out, rsp_flags}), 128'(0));
    chk("reset_fpu_inputs", 128'({opa, opb, fpu_op, rmode}), 128'(0));
    chk("reset_perf", 128'(perf_cnt), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Five back-to-back grants to the only valid requester
    repeat (5) drive(4'b0001, 0);
    drain();
`ifdef FPU_ARB_PERF_EN
    chk("perf_req0", 128'(perf_cnt[15:0]), 128'(5));
    chk("perf_others", 128'(perf_cnt[63:16]), 128'(0));
`else
    chk("perf_tied_zero", 128'(perf_cnt), 128'(0));
`endif

    // Full contention from ptr=0
    do_reset('0);
    for (int k = 0; k < 8; k++) drive(4'b1111, k % 4);
    // Sparse rotation, ptr back at 0
    for (int k = 0; k < 4; k++) drive(4'b1010, (k % 2 == 0) ? 1 : 3);
    drain();

    // Single request: 1.0 + 2.0 from requester 2
    b_opa[2] = 32'h3F80_0000; b_opb[2] = 32'h4000_0000; b_op[2] = 3'd0; b_rm[2] = 2'd0;
    drive(4'b0100, 2, 1'b1, 32'h4040_0000, 8'h00);
    drain();

    // Flags passthrough: 1.0 / 0.0 from requester 1, ptr wraps 3 -> 1
    b_opa[1] = 32'h3F80_0000; b_opb[1] = 32'h0; b_op[1] = 3'd3; b_rm[1] = 2'd0;
    drive(4'b0010, 1, 1'b1, 32'h7F80_0000, 8'h81);
    drain();

    // Enable drops with one op in flight: no grants, but the op completes
    drive(4'b1111, 2);
    en = 1'b0;
    repeat (4) drive(4'b1111, -1);
    en = 1'b1;
    drain();

    // Reset mid-flight: three ops leave ptr at 2, and reset must return it to 0
    drive(4'b1111, 3);
    drive(4'b1111, 0);
    drive(4'b1111, 1);
    do_reset(4'b1111);
    drive(4'b1010, 1);
    drain();
    repeat (6) drive('0, -1);

    chk("scoreboard_empty", 128'(sb.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_issue_arbiter.md
# fpu_issue_arbiter

Round-robin issue arbiter that shares one pipelined FPU core among NUM_REQ requesters. Each requester offers an operation (opa, opb, fpu_op, rmode) through a valid/ready handshake. The arbiter registers one winner per cycle into the FPU inputs and tracks the winner's ID through a tag pipeline matched to the FPU latency. It routes each result and its exception flags back to the issuing requester. The block sits between the client blocks and the FPU core, and drives the same signal set carried by the dut_in/dut_out bench interfaces.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- LATENCY, 4, FPU cycles from registered inputs to valid out/flags
- IDW, 2, requester ID width, equal to clog2(NUM_REQ)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  issue enable; when 0, no grants are made
- req_valid  in  NUM_REQ  per-requester operation valid
- req_ready  out  NUM_REQ  one-hot grant; the handshake completes when valid and ready are both 1
- req_opa, req_opb  in  NUM_REQ*32  packed operands; requester i uses slice [32i+31:32i]
- req_fpu_op  in  NUM_REQ*3  packed opcodes
- req_rmode  in  NUM_REQ*2  packed rounding modes
- opa, opb  out  32  registered operands to the FPU
- fpu_op  out  3  registered opcode
- rmode  out  2  registered rounding mode
- out  in  32  FPU result
- fpu_flags  in  8  FPU flags {inf, snan, qnan, ine, overflow, underflow, zero, div_by_zero}
- rsp_valid  out  NUM_REQ  one-hot, one-cycle result strobe
- rsp_out  out  32  registered result
- rsp_flags  out  8  registered flags, same order as fpu_flags
- perf_cnt  out  NUM_REQ*16  per-requester grant counters

## Operation
- Arbitration is combinational from req_valid, en and the pointer ptr (IDW bits).
  - The grant goes to the first i at or after ptr, with wrap, for which req_valid[i]=1.
  - req_ready[i]=1 only for that i. All zero when en=0 or no requester is valid.
  - req_ready depends on req_valid. Requesters must not make req_valid depend on req_ready.
- On a grant to i:
  - ptr <= (i+1) mod NUM_REQ.
  - opa, opb, fpu_op and rmode load requester i's slices.
  - Stage 0 of the tag pipeline loads {1'b1, i}.
- With no grant: ptr holds, the FPU input registers hold, and stage 0 loads its valid bit as 0.
- Tag pipeline: LATENCY+1 stages of {valid, id}, shifting every cycle with no stall.
- At the last stage:
  - If valid=1: rsp_valid <= onehot(id), rsp_out <= out, rsp_flags <= fpu_flags.
  - If valid=0: rsp_valid <= 0. rsp_out and rsp_flags hold.
- Responses cannot be back-pressured. A requester must sink rsp_valid in the cycle it is asserted.
- Results return in issue order. One response per cycle at most.

## Timing
- Handshake in cycle t:
  - FPU inputs are valid in t+1.
  - The FPU result is valid in t+1+LATENCY.
  - rsp_valid is high in t+2+LATENCY, for exactly 1 cycle.
- Throughput is 1 operation per cycle. Back-to-back grants are allowed, including repeated grants to the same requester when it is the only one valid.
- Reset (rst=1 at an edge) sets: ptr=0, all tag valid bits=0, rsp_valid=0, rsp_out=0, rsp_flags=0, opa=0, opb=0, fpu_op=0, rmode=0, perf_cnt=0.
  - req_ready is 0 while rst=1.
- Reset mid-operation drops all in-flight operations. No rsp_valid is generated for them, and none appears after reset deasserts.
- Toggling en does not affect operations already in flight. They still complete and respond.
- Simultaneous valid from all requesters: grants rotate 0,1,2,3,0,… from ptr=0.

## Configuration
- Macro: FPU_ARB_PERF_EN.
  - Defined: perf_cnt[16i+15:16i] increments on each grant to requester i. The counter saturates at 16'hFFFF and is cleared by rst.
  - Undefined: no counter flops are built, and perf_cnt is tied to 0.
- Arbitration and datapath behaviour are identical in both builds.

## Test plan
- Single request: NUM_REQ=4, LATENCY=4. Requester 2 issues opa=32'h3F800000, opb=32'h40000000, fpu_op=0 (add), rmode=0 in cycle t.
  - Expected: rsp_valid=4'b0100 in t+6 only, rsp_out=32'h40400000, rsp_flags=0.
- Full contention: all 4 valid for 8 cycles after reset.
  - Expected grants in order 0,1,2,3,0,1,2,3.
  - Eight responses return in the same order, each 6 cycles after its grant.
- Sparse rotation: requesters 1 and 3 valid continuously, ptr=0.
  - Expected grants alternate 1,3,1,3, with no cycle lacking a grant.
- Flags passthrough: 1.0/0.0 (fpu_op=3).
  - Expected: rsp_flags has div_by_zero=1 and inf=1, and rsp_out=32'h7F800000.
- Reset mid-flight: issue 3 ops, then assert rst for 1 cycle at t+3.
  - Expected: no rsp_valid afterwards, ptr=0, and the next grant goes to the lowest valid requester.
- Enable and counters:
  - en=0 with all valid: req_ready stays 0 and no responses follow.
  - With FPU_ARB_PERF_EN defined: 5 grants to requester 0 give perf_cnt[15:0]=5. Without the macro, perf_cnt=0.
